// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Line drivers are active-high pull-low enables for external open-drain buffers.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES   = 2838,
    parameter int unsigned REQ_SETUP_CYCLES = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 425000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned PH_CYCLES = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ?
                                        INHIBIT_CYCLES : REQ_SETUP_CYCLES;
    localparam int unsigned PH_W = $clog2(PH_CYCLES);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      tx_byte;
    logic            par;
    logic            ok;

    logic clk_s1, clk_s2, clk_d;
    logic data_s1, data_s2;
    logic fall;

    // Two-flop synchronizers plus one delay stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            to_cnt      <= '0;
            bit_idx     <= '0;
            tx_byte     <= '0;
            par         <= 1'b0;
            ok          <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        tx_byte    <= tx_data;
                        par        <= ~^tx_data;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        phase_cnt  <= '0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (phase_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
                        phase_cnt   <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                REQ: begin
                    if (phase_cnt == PH_W'(REQ_SETUP_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        ps2_clk_oe <= 1'b0;
                        to_cnt     <= '0;
                        bit_idx    <= '0;
                        state      <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                default: begin
                    // Device-clocked phase; the timeout wins over a same-cycle edge
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        to_cnt      <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        tx_error    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        case (state)
                            SHIFT: begin
                                if (fall) begin
                                    ps2_data_oe <= ~tx_byte[bit_idx];
                                    if (bit_idx == 3'd7) begin
                                        state <= PARITY;
                                    end else begin
                                        bit_idx <= bit_idx + 3'd1;
                                    end
                                end
                            end
                            PARITY: begin
                                if (fall) begin
                                    ps2_data_oe <= ~par;
                                    state       <= STOP;
                                end
                            end
                            STOP: begin
                                if (fall) begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ACK;
                                end
                            end
                            ACK: begin
                                if (fall) begin
                                    ok    <= ~data_s2;
                                    state <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_s2 && data_s2) begin
                                    tx_done  <= ok;
                                    tx_error <= ~ok;
                                    busy     <= 1'b0;
                                    state    <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
